// File: rtl/rob_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rob_pkg
// Description : Shared sizing constants, entry record and controller state
//               encoding for the reorder buffer. The rename stage and the
//               physical-register free list use the same width constants.
// Revision    : 1.0 - initial release
// ============================================================================
package rob_pkg;

    localparam int NUM_PHYS_REGS = 64;
    localparam int NUM_ARCH_REGS = 32;
    localparam int ROB_ENTRIES   = 16;

    localparam int LOG_PHYS = $clog2(NUM_PHYS_REGS);
    localparam int LOG_ARCH = $clog2(NUM_ARCH_REGS);
    localparam int LOG_ROB  = $clog2(ROB_ENTRIES);

    typedef logic [LOG_PHYS-1:0] phys_t;
    typedef logic [LOG_ARCH-1:0] arch_t;
    typedef logic [LOG_ROB-1:0]  tag_t;
    // One extra bit so that a full buffer is distinguishable from an empty one.
    typedef logic [LOG_ROB:0]    count_t;

    typedef struct packed {
        logic  valid;
        logic  done;
        logic  has_dest;
        arch_t arch;
        phys_t new_phys;
        phys_t old_phys;
    } rob_entry_t;

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_WALK   = 1'b1
    } rob_state_t;

endpackage
`default_nettype wire

// File: rtl/reorder_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : reorder_buffer_if
// Description : Dispatch / completion / flush / free-list bundle of the
//               reorder buffer.
//               master : rename-dispatch side (drives *_IN, reads *_OUT)
//               slave  : the reorder buffer itself
// Revision    : 1.0 - initial release
// ============================================================================
interface reorder_buffer_if;
    import rob_pkg::*;

    logic  Dispatch_IN;
    logic  DispatchHasDest_IN;
    arch_t DispatchArch_IN;
    phys_t DispatchNewPhys_IN;
    phys_t DispatchOldPhys_IN;
    logic  DispatchReady_OUT;
    tag_t  DispatchTag_OUT;
    logic  Complete_IN;
    tag_t  CompleteTag_IN;
    logic  Flush_IN;
    logic  Enqueue_OUT;
    phys_t Data_OUT;
    logic  CommitValid_OUT;
    arch_t CommitArch_OUT;
    phys_t CommitPhys_OUT;
    logic  Empty_OUT;

    modport master (
        output Dispatch_IN, DispatchHasDest_IN, DispatchArch_IN,
               DispatchNewPhys_IN, DispatchOldPhys_IN,
               Complete_IN, CompleteTag_IN, Flush_IN,
        input  DispatchReady_OUT, DispatchTag_OUT, Enqueue_OUT, Data_OUT,
               CommitValid_OUT, CommitArch_OUT, CommitPhys_OUT, Empty_OUT
    );

    modport slave (
        input  Dispatch_IN, DispatchHasDest_IN, DispatchArch_IN,
               DispatchNewPhys_IN, DispatchOldPhys_IN,
               Complete_IN, CompleteTag_IN, Flush_IN,
        output DispatchReady_OUT, DispatchTag_OUT, Enqueue_OUT, Data_OUT,
               CommitValid_OUT, CommitArch_OUT, CommitPhys_OUT, Empty_OUT
    );

endinterface
`default_nettype wire

// File: rtl/rob_storage.sv
`default_nettype none
// ============================================================================
// Module      : rob_storage
// Description : Entry array of the reorder buffer.
//               clk, rst              : clock, synchronous reset (valid bits)
//               wr_en/wr_tag/wr_entry : dispatch write port
//               done_en/done_tag      : completion port (only valid entries)
//               clr_en/clr_tag        : invalidate port (retire or walk pop)
//               head_tag/head_entry   : async read of the oldest entry
//               walk_tag/walk_*       : async read of the youngest entry
// Revision    : 1.0 - initial release
// ============================================================================
module rob_storage
    import rob_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       wr_en,
    input  wire tag_t       wr_tag,
    input  wire rob_entry_t wr_entry,
    input  wire logic       done_en,
    input  wire tag_t       done_tag,
    input  wire logic       clr_en,
    input  wire tag_t       clr_tag,
    input  wire tag_t       head_tag,
    output rob_entry_t      head_entry,
    input  wire tag_t       walk_tag,
    output logic            walk_has_dest,
    output phys_t           walk_new_phys
);

    rob_entry_t r_mem [ROB_ENTRIES];

    // Port collisions cannot occur: the dispatch slot is only written when
    // the buffer is not full, so it never aliases a valid head being retired
    // or a valid entry being completed.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROB_ENTRIES; i++) begin
                r_mem[i].valid <= 1'b0;
            end
        end else begin
            if (wr_en) begin
                r_mem[wr_tag] <= wr_entry;
            end
            if (done_en && r_mem[done_tag].valid) begin
                r_mem[done_tag].done <= 1'b1;
            end
            if (clr_en) begin
                r_mem[clr_tag].valid <= 1'b0;
            end
        end
    end

    assign head_entry    = r_mem[head_tag];
    assign walk_has_dest = r_mem[walk_tag].has_dest;
    assign walk_new_phys = r_mem[walk_tag].new_phys;

endmodule
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : reorder_buffer
// Description : In-order retirement buffer between dispatch and the
//               physical-register free list. Retire returns the superseded
//               mapping; a flush walks back from the youngest entry returning
//               each squashed new mapping, one register per cycle.
//               CLK, RESET : clock, synchronous active-high reset
//               bus        : dispatch/complete/flush inputs, free-list enqueue,
//                            commit and status outputs (slave modport)
// Revision    : 1.0 - initial release
// ============================================================================
module reorder_buffer
    import rob_pkg::*;
(
    input  wire logic           CLK,
    input  wire logic           RESET,
    reorder_buffer_if.slave     bus
);

    rob_state_t r_state;
    tag_t       r_head;
    tag_t       r_tail;
    count_t     r_count;
    logic       r_enq;
    phys_t      r_data;
    logic       r_commit_valid;
    arch_t      r_commit_arch;
    phys_t      r_commit_phys;

    rob_entry_t w_head_entry;
    rob_entry_t w_wr_entry;
    logic       w_walk_has_dest;
    phys_t      w_walk_new_phys;
    tag_t       w_tail_m1;
    logic       w_normal;
    logic       w_ready;
    logic       w_dispatch;
    logic       w_complete;
    logic       w_retire;
    logic       w_flush_start;
    logic       w_pop;

    assign w_tail_m1 = r_tail - tag_t'(1);
    assign w_normal  = (r_state == ST_NORMAL);

    // Readiness uses the pre-edge count, so a full buffer refuses a dispatch
    // even in a cycle where the head retires.
    assign w_ready       = w_normal && (r_count < count_t'(ROB_ENTRIES)) && !bus.Flush_IN;
    assign w_dispatch    = bus.Dispatch_IN && w_ready;
    assign w_complete    = w_normal && !bus.Flush_IN && bus.Complete_IN;
    // Done is sampled pre-edge: a completion for the head retires next edge.
    assign w_retire      = w_normal && !bus.Flush_IN && w_head_entry.valid && w_head_entry.done;
    assign w_flush_start = w_normal && bus.Flush_IN && (r_count != '0);
    assign w_pop         = !w_normal;

    assign w_wr_entry = '{valid:    1'b1,
                          done:     1'b0,
                          has_dest: bus.DispatchHasDest_IN,
                          arch:     bus.DispatchArch_IN,
                          new_phys: bus.DispatchNewPhys_IN,
                          old_phys: bus.DispatchOldPhys_IN};

    rob_storage u_storage (
        .clk           (CLK),
        .rst           (RESET),
        .wr_en         (w_dispatch),
        .wr_tag        (r_tail),
        .wr_entry      (w_wr_entry),
        .done_en       (w_complete),
        .done_tag      (bus.CompleteTag_IN),
        .clr_en        (w_retire || w_pop),
        .clr_tag       (w_pop ? w_tail_m1 : r_head),
        .head_tag      (r_head),
        .head_entry    (w_head_entry),
        .walk_tag      (w_tail_m1),
        .walk_has_dest (w_walk_has_dest),
        .walk_new_phys (w_walk_new_phys)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state        <= ST_NORMAL;
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_enq          <= 1'b0;
            r_data         <= '0;
            r_commit_valid <= 1'b0;
            r_commit_arch  <= '0;
            r_commit_phys  <= '0;
        end else begin
            // Strobes are one-cycle pulses; data fields hold their last value.
            r_enq          <= 1'b0;
            r_commit_valid <= 1'b0;
            case (r_state)
                ST_NORMAL: begin
                    if (w_flush_start) begin
                        r_state <= ST_WALK;
                    end else begin
                        if (w_dispatch) begin
                            r_tail <= r_tail + tag_t'(1);
                        end
                        if (w_retire) begin
                            r_head         <= r_head + tag_t'(1);
                            r_commit_valid <= 1'b1;
                            r_commit_arch  <= w_head_entry.arch;
                            r_commit_phys  <= w_head_entry.new_phys;
                            if (w_head_entry.has_dest) begin
                                r_enq  <= 1'b1;
                                r_data <= w_head_entry.old_phys;
                            end
                        end
                        if (w_dispatch && !w_retire) begin
                            r_count <= r_count + count_t'(1);
                        end else if (!w_dispatch && w_retire) begin
                            r_count <= r_count - count_t'(1);
                        end
                    end
                end
                ST_WALK: begin
                    r_tail  <= w_tail_m1;
                    r_count <= r_count - count_t'(1);
                    if (w_walk_has_dest) begin
                        r_enq  <= 1'b1;
                        r_data <= w_walk_new_phys;
                    end
                    if (r_count == count_t'(1)) begin
                        r_state <= ST_NORMAL;
                    end
                end
                default: r_state <= ST_NORMAL;
            endcase
        end
    end

    assign bus.DispatchReady_OUT = w_ready;
    assign bus.DispatchTag_OUT   = r_tail;
    assign bus.Enqueue_OUT       = r_enq;
    assign bus.Data_OUT          = r_data;
    assign bus.CommitValid_OUT   = r_commit_valid;
    assign bus.CommitArch_OUT    = r_commit_arch;
    assign bus.CommitPhys_OUT    = r_commit_phys;
    assign bus.Empty_OUT         = (r_count == '0);

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reorder_buffer
// Description : Self-checking bench for reorder_buffer. Directed scenarios
//               compare against hand-derived constants; a randomized run
//               compares against a queue-based program-order model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reorder_buffer;

    logic CLK = 1'b0;
    logic RESET;

    reorder_buffer_if bus ();

    reorder_buffer dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: entries in program order, oldest first.
    typedef struct {
        bit hd;
        int arch;
        int np;
        int op;
    } m_ent_t;

    m_ent_t m_q[$];
    bit     m_done[$];
    int     m_head = 0;
    bit     m_walk = 0;

    int exp_ready, exp_tag_pre, exp_enq, exp_data, exp_cv, exp_carch, exp_cphys, exp_empty, exp_tag;

    logic [31:0] obs_ready, obs_tag_pre, obs_enq, obs_data, obs_cv, obs_carch, obs_cphys, obs_empty, obs_tag;

    task automatic model_edge(input bit rst, input bit disp, input bit hd, input int arch,
                              input int np, input int op, input bit comp, input int ctag,
                              input bit fl);
        int     sz;
        bit     retire;
        int     idx;
        m_ent_t e;
        sz          = m_q.size();
        exp_ready   = (!m_walk && sz < 16 && !fl) ? 1 : 0;
        exp_tag_pre = (m_head + sz) % 16;
        if (rst) begin
            m_q.delete();
            m_done.delete();
            m_head    = 0;
            m_walk    = 0;
            exp_enq   = 0;
            exp_data  = 0;
            exp_cv    = 0;
            exp_carch = 0;
            exp_cphys = 0;
        end else begin
            exp_enq = 0;
            exp_cv  = 0;
            if (m_walk) begin
                e = m_q.pop_back();
                void'(m_done.pop_back());
                if (e.hd) begin
                    exp_enq  = 1;
                    exp_data = e.np;
                end
                if (m_q.size() == 0) m_walk = 0;
            end else if (fl) begin
                if (sz > 0) m_walk = 1;
            end else begin
                retire = (sz > 0) && m_done[0];
                if (comp) begin
                    idx = (ctag - m_head + 16) % 16;
                    if (idx < sz) m_done[idx] = 1'b1;
                end
                if (retire) begin
                    e = m_q.pop_front();
                    void'(m_done.pop_front());
                    m_head    = (m_head + 1) % 16;
                    exp_cv    = 1;
                    exp_carch = e.arch;
                    exp_cphys = e.np;
                    if (e.hd) begin
                        exp_enq  = 1;
                        exp_data = e.op;
                    end
                end
                if (disp && exp_ready == 1) begin
                    m_q.push_back('{hd: hd, arch: arch, np: np, op: op});
                    m_done.push_back(1'b0);
                end
            end
        end
        exp_empty = (m_q.size() == 0) ? 1 : 0;
        exp_tag   = (m_head + m_q.size()) % 16;
    endtask

    // One clock cycle: drive, sample combinational outputs, clock, sample
    // registered outputs 1 time unit after the edge.
    task automatic cycle(input bit rst, input bit disp, input bit hd, input int arch,
                         input int np, input int op, input bit comp, input int ctag,
                         input bit fl);
        logic [31:0] v;
        RESET = rst;
        bus.Dispatch_IN        = disp;
        bus.DispatchHasDest_IN = hd;
        v = arch; bus.DispatchArch_IN   = v[4:0];
        v = np;   bus.DispatchNewPhys_IN = v[5:0];
        v = op;   bus.DispatchOldPhys_IN = v[5:0];
        bus.Complete_IN = comp;
        v = ctag; bus.CompleteTag_IN = v[3:0];
        bus.Flush_IN = fl;
        #1;
        obs_ready   = 32'(bus.DispatchReady_OUT);
        obs_tag_pre = 32'(bus.DispatchTag_OUT);
        model_edge(rst, disp, hd, arch, np, op, comp, ctag, fl);
        @(posedge CLK);
        #1;
        obs_enq   = 32'(bus.Enqueue_OUT);
        obs_data  = 32'(bus.Data_OUT);
        obs_cv    = 32'(bus.CommitValid_OUT);
        obs_carch = 32'(bus.CommitArch_OUT);
        obs_cphys = 32'(bus.CommitPhys_OUT);
        obs_empty = 32'(bus.Empty_OUT);
        obs_tag   = 32'(bus.DispatchTag_OUT);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        RESET = 1'b0;
        #1;
        n_checks++; if (obs_empty !== 32'd1) $display("FAIL reset_empty got %0d want 1", obs_empty); else n_pass++;
        n_checks++; if (obs_enq !== 32'd0) $display("FAIL reset_enq got %0d want 0", obs_enq); else n_pass++;
        n_checks++; if (obs_tag !== 32'd0) $display("FAIL reset_tag got %0d want 0", obs_tag); else n_pass++;
        n_checks++; if (obs_cv !== 32'd0) $display("FAIL reset_commit got %0d want 0", obs_cv); else n_pass++;
        n_checks++; if (obs_data !== 32'd0) $display("FAIL reset_data got %0d want 0", obs_data); else n_pass++;
        n_checks++; if (bus.DispatchReady_OUT !== 1'b1) $display("FAIL reset_ready got %0b want 1", bus.DispatchReady_OUT); else n_pass++;
    endtask

    task automatic test_in_order();
        cycle(0, 1, 1, 3, 40, 3, 0, 0, 0);   // A -> tag 0
        cycle(0, 1, 1, 5, 41, 5, 0, 0, 0);   // B -> tag 1
        cycle(0, 0, 0, 0, 0, 0, 1, 1, 0);    // complete B
        n_checks++; if (obs_cv !== 32'd0) $display("FAIL ino_no_early_b got %0d want 0", obs_cv); else n_pass++;
        cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);    // complete A
        n_checks++; if (obs_cv !== 32'd0) $display("FAIL ino_no_same_edge got %0d want 0", obs_cv); else n_pass++;
        idle();
        n_checks++; if (obs_cv !== 32'd1) $display("FAIL ino_a_commit got %0d want 1", obs_cv); else n_pass++;
        n_checks++; if (obs_enq !== 32'd1) $display("FAIL ino_a_enq got %0d want 1", obs_enq); else n_pass++;
        n_checks++; if (obs_data !== 32'd3) $display("FAIL ino_a_data got %0d want 3", obs_data); else n_pass++;
        n_checks++; if (obs_cphys !== 32'd40) $display("FAIL ino_a_phys got %0d want 40", obs_cphys); else n_pass++;
        n_checks++; if (obs_carch !== 32'd3) $display("FAIL ino_a_arch got %0d want 3", obs_carch); else n_pass++;
        idle();
        n_checks++; if (obs_data !== 32'd5) $display("FAIL ino_b_data got %0d want 5", obs_data); else n_pass++;
        n_checks++; if (obs_cphys !== 32'd41) $display("FAIL ino_b_phys got %0d want 41", obs_cphys); else n_pass++;
        idle();
        n_checks++; if (obs_cv !== 32'd0) $display("FAIL ino_done_commit got %0d want 0", obs_cv); else n_pass++;
        n_checks++; if (obs_empty !== 32'd1) $display("FAIL ino_empty got %0d want 1", obs_empty); else n_pass++;
    endtask

    task automatic test_full_wrap();
        int k;
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) cycle(0, 1, 1, i, 10 + i, 20 + i, 0, 0, 0);
        n_checks++; if (obs_empty !== 32'd0) $display("FAIL full_not_empty got %0d want 0", obs_empty); else n_pass++;
        n_checks++; if (obs_tag !== 32'd0) $display("FAIL full_tag_wrap got %0d want 0", obs_tag); else n_pass++;
        // 17th dispatch together with completion of the head while full.
        cycle(0, 1, 1, 9, 9, 9, 1, 0, 0);
        n_checks++; if (obs_ready !== 32'd0) $display("FAIL full_ready got %0d want 0", obs_ready); else n_pass++;
        n_checks++; if (obs_cv !== 32'd0) $display("FAIL full_no_commit got %0d want 0", obs_cv); else n_pass++;
        n_checks++; if (obs_tag !== 32'd0) $display("FAIL full_drop_tag got %0d want 0", obs_tag); else n_pass++;
        k = 0;
        for (int t = 1; t < 16; t++) begin
            cycle(0, 0, 0, 0, 0, 0, 1, t, 0);
            if (obs_cv === 32'd1) begin
                n_checks++; if (obs_cphys !== 32'(10 + k)) $display("FAIL wrap_phys%0d got %0d want %0d", k, obs_cphys, 10 + k); else n_pass++;
                n_checks++; if (obs_data !== 32'(20 + k)) $display("FAIL wrap_data%0d got %0d want %0d", k, obs_data, 20 + k); else n_pass++;
                k++;
            end
        end
        for (int w = 0; w < 30 && k < 16; w++) begin
            idle();
            if (obs_cv === 32'd1) begin
                n_checks++; if (obs_cphys !== 32'(10 + k)) $display("FAIL wrap_phys%0d got %0d want %0d", k, obs_cphys, 10 + k); else n_pass++;
                n_checks++; if (obs_data !== 32'(20 + k)) $display("FAIL wrap_data%0d got %0d want %0d", k, obs_data, 20 + k); else n_pass++;
                k++;
            end
        end
        n_checks++; if (k != 16) $display("FAIL wrap_count got %0d want 16", k); else n_pass++;
        idle();
        n_checks++; if (obs_cv !== 32'd0) $display("FAIL wrap_extra_commit got %0d want 0", obs_cv); else n_pass++;
        n_checks++; if (obs_empty !== 32'd1) $display("FAIL wrap_empty got %0d want 1", obs_empty); else n_pass++;
        n_checks++; if (obs_tag !== 32'd0) $display("FAIL wrap_tag got %0d want 0", obs_tag); else n_pass++;
    endtask

    task automatic test_flush_walk();
        cycle(0, 1, 1, 1, 50, 1, 0, 0, 0);
        cycle(0, 1, 0, 2, 51, 2, 0, 0, 0);
        cycle(0, 1, 1, 3, 52, 3, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
        n_checks++; if (obs_ready !== 32'd0) $display("FAIL fl_ready_flush got %0d want 0", obs_ready); else n_pass++;
        n_checks++; if (obs_enq !== 32'd0) $display("FAIL fl_enq_flush got %0d want 0", obs_enq); else n_pass++;
        // Walk cycles: dispatch, completion and flush must all be ignored.
        cycle(0, 1, 1, 7, 7, 7, 1, 0, 1);
        n_checks++; if (obs_ready !== 32'd0) $display("FAIL fl_ready_w1 got %0d want 0", obs_ready); else n_pass++;
        n_checks++; if (obs_enq !== 32'd1 || obs_data !== 32'd52) $display("FAIL fl_w1 got enq %0d data %0d want 1/52", obs_enq, obs_data); else n_pass++;
        cycle(0, 1, 1, 7, 7, 7, 0, 0, 0);
        n_checks++; if (obs_ready !== 32'd0) $display("FAIL fl_ready_w2 got %0d want 0", obs_ready); else n_pass++;
        n_checks++; if (obs_enq !== 32'd0) $display("FAIL fl_w2_nodest got %0d want 0", obs_enq); else n_pass++;
        cycle(0, 1, 1, 7, 7, 7, 0, 0, 0);
        n_checks++; if (obs_ready !== 32'd0) $display("FAIL fl_ready_w3 got %0d want 0", obs_ready); else n_pass++;
        n_checks++; if (obs_enq !== 32'd1 || obs_data !== 32'd50) $display("FAIL fl_w3 got enq %0d data %0d want 1/50", obs_enq, obs_data); else n_pass++;
        n_checks++; if (obs_empty !== 32'd1) $display("FAIL fl_empty got %0d want 1", obs_empty); else n_pass++;
        idle();
        n_checks++; if (obs_ready !== 32'd1) $display("FAIL fl_ready_back got %0d want 1", obs_ready); else n_pass++;
        n_checks++; if (obs_enq !== 32'd0) $display("FAIL fl_enq_after got %0d want 0", obs_enq); else n_pass++;
        n_checks++; if (obs_empty !== 32'd1) $display("FAIL fl_empty_after got %0d want 1", obs_empty); else n_pass++;
    endtask

    task automatic test_flush_head_done();
        int t0;
        t0 = int'(bus.DispatchTag_OUT);
        cycle(0, 1, 1, 4, 30, 7, 0, 0, 0);
        cycle(0, 1, 1, 6, 31, 8, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, t0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
        n_checks++; if (obs_cv !== 32'd0) $display("FAIL fhd_commit got %0d want 0", obs_cv); else n_pass++;
        n_checks++; if (obs_enq !== 32'd0) $display("FAIL fhd_enq got %0d want 0", obs_enq); else n_pass++;
        idle();
        n_checks++; if (obs_enq !== 32'd1 || obs_data !== 32'd31) $display("FAIL fhd_w1 got enq %0d data %0d want 1/31", obs_enq, obs_data); else n_pass++;
        idle();
        n_checks++; if (obs_enq !== 32'd1 || obs_data !== 32'd30) $display("FAIL fhd_w2 got enq %0d data %0d want 1/30", obs_enq, obs_data); else n_pass++;
        idle();
        n_checks++; if (obs_cv !== 32'd0 || obs_enq !== 32'd0) $display("FAIL fhd_ghost got cv %0d enq %0d want 0/0", obs_cv, obs_enq); else n_pass++;
    endtask

    task automatic test_reset_mid_walk();
        for (int i = 0; i < 4; i++) cycle(0, 1, 1, i, 60 + i, i, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle();
        n_checks++; if (obs_enq !== 32'd1 || obs_data !== 32'd63) $display("FAIL rmw_w1 got enq %0d data %0d want 1/63", obs_enq, obs_data); else n_pass++;
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        n_checks++; if (obs_enq !== 32'd0) $display("FAIL rmw_enq got %0d want 0", obs_enq); else n_pass++;
        n_checks++; if (obs_empty !== 32'd1) $display("FAIL rmw_empty got %0d want 1", obs_empty); else n_pass++;
        n_checks++; if (obs_tag !== 32'd0) $display("FAIL rmw_tag got %0d want 0", obs_tag); else n_pass++;
        idle();
        n_checks++; if (obs_ready !== 32'd1) $display("FAIL rmw_ready got %0d want 1", obs_ready); else n_pass++;
        n_checks++; if (obs_enq !== 32'd0) $display("FAIL rmw_enq2 got %0d want 0", obs_enq); else n_pass++;
    endtask

    task automatic test_random();
        bit rst, disp, hd, comp, fl;
        int ctag;
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 600; c++) begin
            rst  = ($urandom_range(0, 199) == 0);
            disp = ($urandom_range(0, 99) < 60);
            hd   = ($urandom_range(0, 99) < 75);
            comp = ($urandom_range(0, 99) < 70);
            fl   = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 9) == 0) ctag = $urandom_range(0, 15);
            else ctag = (m_head + $urandom_range(0, m_q.size())) % 16;
            cycle(rst, disp, hd, $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63), comp, ctag, fl);
            if (!rst) begin
                n_checks++; if (obs_ready !== 32'(exp_ready)) $display("FAIL rnd_ready c%0d got %0d want %0d", c, obs_ready, exp_ready); else n_pass++;
                n_checks++; if (obs_tag_pre !== 32'(exp_tag_pre)) $display("FAIL rnd_tag c%0d got %0d want %0d", c, obs_tag_pre, exp_tag_pre); else n_pass++;
            end
            n_checks++; if (obs_enq !== 32'(exp_enq)) $display("FAIL rnd_enq c%0d got %0d want %0d", c, obs_enq, exp_enq); else n_pass++;
            n_checks++; if (obs_data !== 32'(exp_data)) $display("FAIL rnd_data c%0d got %0d want %0d", c, obs_data, exp_data); else n_pass++;
            n_checks++; if (obs_cv !== 32'(exp_cv)) $display("FAIL rnd_commit c%0d got %0d want %0d", c, obs_cv, exp_cv); else n_pass++;
            n_checks++; if (obs_carch !== 32'(exp_carch)) $display("FAIL rnd_carch c%0d got %0d want %0d", c, obs_carch, exp_carch); else n_pass++;
            n_checks++; if (obs_cphys !== 32'(exp_cphys)) $display("FAIL rnd_cphys c%0d got %0d want %0d", c, obs_cphys, exp_cphys); else n_pass++;
            n_checks++; if (obs_empty !== 32'(exp_empty)) $display("FAIL rnd_empty c%0d got %0d want %0d", c, obs_empty, exp_empty); else n_pass++;
            n_checks++; if (obs_tag !== 32'(exp_tag)) $display("FAIL rnd_tail c%0d got %0d want %0d", c, obs_tag, exp_tag); else n_pass++;
        end
    endtask

    initial begin
        RESET                  = 1'b1;
        bus.Dispatch_IN        = 1'b0;
        bus.DispatchHasDest_IN = 1'b0;
        bus.DispatchArch_IN    = '0;
        bus.DispatchNewPhys_IN = '0;
        bus.DispatchOldPhys_IN = '0;
        bus.Complete_IN        = 1'b0;
        bus.CompleteTag_IN     = '0;
        bus.Flush_IN           = 1'b0;
        @(posedge CLK);
        #1;
        test_reset();
        test_in_order();
        test_full_wrap();
        test_flush_walk();
        test_flush_head_done();
        test_reset_mid_walk();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
